// File: rtl/wb_intercon.sv
// wb_intercon: single-master Wishbone interconnect.
// Decodes the top SEL_W address bits into one of NUM_SLAVES one-hot slave strobes, then returns
// a registered ACK with the selected slave's read data. An access that hits an unmapped index,
// or whose slave stays silent for TIMEOUT strobe cycles, completes with a one-cycle ERR instead.
//
// Ports
//   clk_i, rst_i             clock; asynchronous active-low reset
//   stb_i/we_i/adr_i/dat_i   master request (stb_i held until ack_o or err_o)
//   dat_o/ack_o/err_o        registered master response
//   slv_stb_o               one-hot slave strobes
//   slv_we_o/slv_adr_o/slv_dat_o  registered request copies towards the slaves
//   slv_dat_i/slv_ack_i     slave read data (slave k at [k*DAT_W +: DAT_W]) and acks
//   err_cnt_o/last_err_adr_o  error statistics
//
// Optional feature: define WB_ICON_STATS_EN to build the saturating error counter and the
// last-error address capture. Otherwise both outputs are tied to zero.
module wb_intercon #(
  parameter int unsigned NUM_SLAVES = 12,
  parameter int unsigned ADR_W      = 8,
  parameter int unsigned DAT_W      = 8,
  parameter int unsigned SEL_W      = 4,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        stb_i,
  input  logic                        we_i,
  input  logic [ADR_W-1:0]            adr_i,
  input  logic [DAT_W-1:0]            dat_i,
  output logic [DAT_W-1:0]            dat_o,
  output logic                        ack_o,
  output logic                        err_o,
  output logic [NUM_SLAVES-1:0]       slv_stb_o,
  output logic                        slv_we_o,
  output logic [ADR_W-SEL_W-1:0]      slv_adr_o,
  output logic [DAT_W-1:0]            slv_dat_o,
  input  logic [NUM_SLAVES*DAT_W-1:0] slv_dat_i,
  input  logic [NUM_SLAVES-1:0]       slv_ack_i,
  output logic [7:0]                  err_cnt_o,
  output logic [ADR_W-1:0]            last_err_adr_o
);

  localparam int unsigned WdW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

  state_e                  state_q;
  logic [ADR_W-1:0]        adr_q;
  logic [WdW-1:0]          wd_q;
  logic [SEL_W-1:0]        req_idx;
  logic [SEL_W-1:0]        idx_q;
  logic                    req_mapped;
  logic [NUM_SLAVES-1:0]   req_onehot;
  logic                    hit_ack;
  logic [DAT_W-1:0]        rd_data;
  logic                    wd_expired;

  assign req_idx   = adr_i[ADR_W-1 -: SEL_W];
  assign idx_q     = adr_q[ADR_W-1 -: SEL_W];
  assign slv_adr_o = adr_q[ADR_W-SEL_W-1:0];

  // Request decode uses the live address; ack/data select uses the latched index so master
  // activity during BUSY cannot disturb the access in flight.
  always_comb begin
    req_mapped = 1'b0;
    req_onehot = '0;
    hit_ack    = 1'b0;
    rd_data    = '0;
    for (int k = 0; k < NUM_SLAVES; k++) begin
      if (req_idx == SEL_W'(k)) begin
        req_mapped    = 1'b1;
        req_onehot[k] = 1'b1;
      end
      if (idx_q == SEL_W'(k)) begin
        hit_ack = slv_ack_i[k];
        rd_data = slv_dat_i[k*DAT_W +: DAT_W];
      end
    end
  end

  // wd_q counts completed BUSY cycles; the TIMEOUT-th silent cycle is the last one.
  assign wd_expired = (TIMEOUT != 0) && (wd_q == WdW'(TIMEOUT - 1));

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= StIdle;
      adr_q     <= '0;
      wd_q      <= '0;
      dat_o     <= '0;
      ack_o     <= 1'b0;
      err_o     <= 1'b0;
      slv_stb_o <= '0;
      slv_we_o  <= 1'b0;
      slv_dat_o <= '0;
    end else begin
      ack_o <= 1'b0;
      err_o <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (stb_i) begin
            adr_q     <= adr_i;
            slv_we_o  <= we_i;
            slv_dat_o <= dat_i;
            wd_q      <= '0;
            if (req_mapped) begin
              slv_stb_o <= req_onehot;
              state_q   <= StBusy;
            end else begin
              err_o   <= 1'b1;
              dat_o   <= '0;
              state_q <= StResp;
            end
          end
        end
        StBusy: begin
          // An ack on the final watchdog cycle takes priority over the timeout.
          if (hit_ack) begin
            dat_o     <= rd_data;
            ack_o     <= 1'b1;
            slv_stb_o <= '0;
            state_q   <= StResp;
          end else if (wd_expired) begin
            dat_o     <= '0;
            err_o     <= 1'b1;
            slv_stb_o <= '0;
            state_q   <= StResp;
          end else if (TIMEOUT != 0) begin
            wd_q <= wd_q + 1'b1;
          end
        end
        StResp: begin
          dat_o   <= '0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef WB_ICON_STATS_EN
  logic [7:0]       err_cnt_q;
  logic [ADR_W-1:0] last_err_q;

  // adr_q is stable through RESP, so it is the full address of the failed access.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      err_cnt_q  <= '0;
      last_err_q <= '0;
    end else if (err_o) begin
      if (err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
      last_err_q <= adr_q;
    end
  end

  assign err_cnt_o      = err_cnt_q;
  assign last_err_adr_o = last_err_q;
`else
  assign err_cnt_o      = '0;
  assign last_err_adr_o = '0;
`endif

endmodule

// File: tb/tb_wb_intercon.sv
module tb_wb_intercon;

  localparam int NS = 12;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          stb_i, we_i;
  logic [7:0]    adr_i, dat_i, dat_o;
  logic          ack_o, err_o;
  logic [NS-1:0] slv_stb_o;
  logic          slv_we_o;
  logic [3:0]    slv_adr_o;
  logic [7:0]    slv_dat_o;
  logic [NS*8-1:0] slv_dat_i;
  logic [NS-1:0] slv_ack_i;
  logic [7:0]    err_cnt_o, last_err_adr_o;

  int n_cmp = 0;
  int n_fail = 0;
  int exp_errs = 0;
  logic [7:0] exp_last = 8'h00;

  // Slave models: per-slave wait states, global mute, forced foreign acks.
  logic [3:0]    wait_st [NS];
  logic [7:0]    rdata   [NS];
  logic [3:0]    scnt    [NS];
  logic          mute;
  logic [NS-1:0] foreign;

  always #5 clk_i = ~clk_i;

  wb_intercon #(.NUM_SLAVES(NS), .ADR_W(8), .DAT_W(8), .SEL_W(4), .TIMEOUT(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .stb_i(stb_i), .we_i(we_i), .adr_i(adr_i), .dat_i(dat_i),
    .dat_o(dat_o), .ack_o(ack_o), .err_o(err_o), .slv_stb_o(slv_stb_o), .slv_we_o(slv_we_o),
    .slv_adr_o(slv_adr_o), .slv_dat_o(slv_dat_o), .slv_dat_i(slv_dat_i),
    .slv_ack_i(slv_ack_i), .err_cnt_o(err_cnt_o), .last_err_adr_o(last_err_adr_o)
  );

  always @(posedge clk_i) begin
    for (int k = 0; k < NS; k++) scnt[k] <= slv_stb_o[k] ? scnt[k] + 4'd1 : 4'd0;
  end

  always_comb begin
    slv_ack_i = '0;
    slv_dat_i = '0;
    for (int k = 0; k < NS; k++) begin
      slv_ack_i[k] = (slv_stb_o[k] && !mute && scnt[k] == wait_st[k]) || foreign[k];
      slv_dat_i[k*8 +: 8] = rdata[k];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic chk_stats(input string name);
`ifdef WB_ICON_STATS_EN
    chk({name, ".err_cnt"}, err_cnt_o, exp_errs);
    chk({name, ".last_err"}, last_err_adr_o, exp_last);
`else
    chk({name, ".err_cnt"}, err_cnt_o, 0);
    chk({name, ".last_err"}, last_err_adr_o, 0);
`endif
  endtask

  // Issue one access starting at a negedge; returns at #1 after the response edge.
  task automatic do_access(input logic [7:0] adr, input logic we, input logic [7:0] wd,
                           output logic got_ack, output logic got_err, output logic [7:0] got_dat,
                           output int lat, output int stb_n, output logic [NS-1:0] stb_or,
                           output logic [3:0] s_adr, output logic s_we, output logic [7:0] s_dat);
    int cyc = 0;
    got_ack = 0; got_err = 0; got_dat = 0; lat = 0; stb_n = 0; stb_or = '0;
    s_adr = 0; s_we = 0; s_dat = 0;
    @(negedge clk_i);
    stb_i = 1; we_i = we; adr_i = adr; dat_i = wd;
    while (cyc < 20) begin
      @(posedge clk_i); #1;
      cyc++;
      if (slv_stb_o != '0) begin
        if (stb_n == 0) begin s_adr = slv_adr_o; s_we = slv_we_o; s_dat = slv_dat_o; end
        stb_n++;
        stb_or |= slv_stb_o;
      end
      if (ack_o || err_o) begin
        got_ack = ack_o; got_err = err_o; got_dat = dat_o; lat = cyc;
        break;
      end
    end
    stb_i = 0; we_i = 0;
    if (lat == 0) begin
      n_cmp++; n_fail++;
      $display("FAIL access %0h: no response within 20 cycles", adr);
    end
  endtask

  typedef struct {
    logic [7:0]    adr;
    logic          we;
    logic [7:0]    wdat;
    logic [3:0]    wst;
    logic          mute;
    logic          exp_ack;
    logic          exp_err;
    logic [7:0]    exp_dat;
    int            exp_lat;
    int            exp_stb_n;
    logic [NS-1:0] exp_stb;
  } vec_t;

  vec_t vecs [7];

  initial begin
    logic ga, ge, swe;
    logic [7:0] gd, sdat;
    logic [3:0] sadr;
    logic [NS-1:0] sor;
    int lat, sn, acks, errs, ack2_cyc;
    logic [7:0] d1, d2;

    rst_i = 0; stb_i = 0; we_i = 0; adr_i = 0; dat_i = 0; mute = 0; foreign = '0;
    for (int k = 0; k < NS; k++) begin
      wait_st[k] = 0;
      rdata[k] = 8'h50 + 8'(k);
    end
    rdata[3] = 8'hA5;

    //            adr    we  wdat   wst  mute ack err dat  lat n  stb
    vecs[0] = '{8'h32, 0, 8'h00, 0, 0, 1, 0, 8'hA5, 2, 1, 12'h008};
    vecs[1] = '{8'h05, 1, 8'h3C, 3, 0, 1, 0, 8'h50, 5, 4, 12'h001};
    vecs[2] = '{8'hD0, 0, 8'h00, 0, 0, 0, 1, 8'h00, 1, 0, 12'h000};
    vecs[3] = '{8'h7E, 0, 8'h00, 0, 1, 0, 1, 8'h00, 5, 4, 12'h080};
    vecs[4] = '{8'h71, 0, 8'h00, 3, 0, 1, 0, 8'h57, 5, 4, 12'h080};
    vecs[5] = '{8'hC0, 0, 8'h00, 0, 0, 0, 1, 8'h00, 1, 0, 12'h000};
    vecs[6] = '{8'hBF, 0, 8'h00, 1, 0, 1, 0, 8'h5B, 3, 2, 12'h800};

    repeat (3) @(posedge clk_i);
    #1;
    chk("rst.ack", ack_o, 0);
    chk("rst.err", err_o, 0);
    chk("rst.stb", slv_stb_o, 0);
    chk("rst.dat", dat_o, 0);
    chk_stats("rst");
    @(negedge clk_i);
    rst_i = 1;

    for (int i = 0; i < 7; i++) begin
      string nm;
      nm = $sformatf("v%0d", i);
      for (int k = 0; k < NS; k++) wait_st[k] = vecs[i].wst;
      mute = vecs[i].mute;
      do_access(vecs[i].adr, vecs[i].we, vecs[i].wdat, ga, ge, gd, lat, sn, sor, sadr, swe, sdat);
      chk({nm, ".ack"}, ga, vecs[i].exp_ack);
      chk({nm, ".err"}, ge, vecs[i].exp_err);
      chk({nm, ".dat"}, gd, vecs[i].exp_dat);
      chk({nm, ".lat"}, lat, vecs[i].exp_lat);
      chk({nm, ".stb_cycles"}, sn, vecs[i].exp_stb_n);
      chk({nm, ".stb"}, sor, vecs[i].exp_stb);
      if (vecs[i].exp_stb_n > 0) begin
        chk({nm, ".slv_adr"}, sadr, vecs[i].adr[3:0]);
        chk({nm, ".slv_we"}, swe, vecs[i].we);
        chk({nm, ".slv_dat"}, sdat, vecs[i].wdat);
      end
      if (vecs[i].exp_err) begin
        exp_errs++;
        exp_last = vecs[i].adr;
      end
      @(posedge clk_i); #1;
      chk({nm, ".idle_pulse"}, {ack_o, err_o}, 2'b00);
      chk({nm, ".idle_stb"}, slv_stb_o, 0);
      chk_stats(nm);
    end
    mute = 0;
    for (int k = 0; k < NS; k++) wait_st[k] = 0;

    // Reset while a muted slave is being strobed.
    mute = 1;
    @(negedge clk_i);
    stb_i = 1; adr_i = 8'h70;
    repeat (3) @(posedge clk_i);
    #1;
    chk("rstbusy.stb_before", slv_stb_o, 12'h080);
    rst_i = 0;
    #1;
    chk("rstbusy.stb", slv_stb_o, 0);
    chk("rstbusy.resp", {ack_o, err_o}, 2'b00);
    stb_i = 0; mute = 0;
    @(negedge clk_i);
    rst_i = 1;
    exp_errs = 0; exp_last = 0;
    chk_stats("rstbusy");
    repeat (6) @(posedge clk_i);
    #1;
    chk("rstbusy.no_late_resp", {ack_o, err_o}, 2'b00);
    do_access(8'h32, 0, 8'h00, ga, ge, gd, lat, sn, sor, sadr, swe, sdat);
    chk("postrst.ack", ga, 1);
    chk("postrst.dat", gd, 8'hA5);
    chk("postrst.lat", lat, 2);
    @(posedge clk_i); #1;
    chk_stats("postrst");

    // Back-to-back: slave 1 (2 waits) then slave 2 (0 waits), foreign ack from slave 5 held.
    wait_st[1] = 2; wait_st[2] = 0;
    foreign[5] = 1;
    acks = 0; errs = 0; d1 = 0; d2 = 0; ack2_cyc = 0;
    @(negedge clk_i);
    stb_i = 1; adr_i = 8'h10;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk_i); #1;
      if (err_o) errs++;
      if (ack_o) begin
        acks++;
        if (acks == 1) begin
          d1 = dat_o;
          adr_i = 8'h20;
        end else if (acks == 2) begin
          d2 = dat_o;
          ack2_cyc = c;
          stb_i = 0;
        end
      end
    end
    foreign[5] = 0;
    chk("b2b.acks", acks, 2);
    chk("b2b.errs", errs, 0);
    chk("b2b.dat1", d1, 8'h51);
    chk("b2b.dat2", d2, 8'h52);
    chk("b2b.ack2_cycle", ack2_cyc, 7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
